// File: rtl/lii_pkg.sv
// Shared LII fabric constants and helpers.
package lii_pkg;

    localparam int unsigned LII_ID_W       = 8;
    localparam int unsigned LII_DEFAULT_PW = 128;

    function automatic int unsigned lanes(input int unsigned pw, input int unsigned dw);
        return pw / dw;
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; read data reads as zero while empty.
module lii_sync_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       arstn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lii_out_packer.sv
// Kernel-side LII output stage: packs PACK kernel words per beat, tags them
// with constant IDs and buffers beats in a FWFT FIFO toward the phy.
module lii_out_packer
    import lii_pkg::*;
#(
    parameter int unsigned          DW     = 32,
    parameter int unsigned          PW     = LII_DEFAULT_PW,
    parameter int unsigned          PACK   = 1,
    parameter int unsigned          DEPTH  = 4,
    parameter logic [LII_ID_W-1:0]  SRC_ID = 8'd0,
    parameter logic [LII_ID_W-1:0]  DST_ID = 8'd1
) (
    input  logic                 aclk,
    input  logic                 arstn,
    input  logic [DW-1:0]        k_tdata,
    input  logic                 k_tvalid,
    output logic                 k_tready,
    input  logic                 k_tlast,
    output logic [PW-1:0]        lii_out_p0_tdata,
    output logic                 lii_out_p0_tvalid,
    input  logic                 lii_out_p0_tready,
    output logic [LII_ID_W-1:0]  lii_out_p0_src,
    output logic [LII_ID_W-1:0]  lii_out_p0_dst,
    output logic                 ce
);

    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    if (PW % DW != 0) begin : g_err_pw
        $error("lii_out_packer: PW must be a multiple of DW");
    end
    if (PACK < 1 || PACK > lanes(PW, DW)) begin : g_err_pack
        $error("lii_out_packer: PACK must be in 1..PW/DW");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
        $error("lii_out_packer: DEPTH must be a power of 2, >= 2");
    end

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     beat;
    logic              run_q;
    logic              accept;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // run_q holds ready low through reset and releases it on the first edge after.
    assign k_tready          = run_q & ~fifo_full;
    assign ce                = k_tready;
    assign accept            = k_tvalid & k_tready;
    assign flush             = (lane_q == LANE_W'(PACK - 1)) | k_tlast;
    assign lii_out_p0_tvalid = ~fifo_empty;
    assign lii_out_p0_src    = SRC_ID;
    assign lii_out_p0_dst    = DST_ID;

    always_comb begin
        beat = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (LANE_W'(i) < lane_q) begin
                beat[i*DW +: DW] = acc_q[i*DW +: DW];
            end else if (LANE_W'(i) == lane_q) begin
                beat[i*DW +: DW] = k_tdata;
            end
        end
    end

    always_comb begin
        acc_d  = acc_q;
        lane_d = lane_q;
        if (accept) begin
            if (flush) begin
                acc_d  = '0;
                lane_d = '0;
            end else begin
                acc_d  = beat;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            lane_q <= '0;
            acc_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            run_q  <= 1'b1;
        end
    end

    lii_sync_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .arstn   (arstn),
        .wr_en   (accept & flush),
        .wr_data (beat),
        .full    (fifo_full),
        .rd_en   (lii_out_p0_tready),
        .rd_data (lii_out_p0_tdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    a_count_bound: assert property (@(posedge aclk) disable iff (!arstn)
        fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_lii_out_packer.sv
// Bench for lii_out_packer: PACK=1 and PACK=4 instances checked every cycle
// against a queue-based beat model, plus literal pins on key beats.
module tb_lii_out_packer;

    logic         aclk = 1'b0;
    logic         arstn = 1'b0;
    logic [31:0]  ktd  [2];
    logic         ktv  [2];
    logic         ktl  [2];
    logic         ktr  [2];
    logic [127:0] otd  [2];
    logic         otv  [2];
    logic         otr  [2];
    logic [7:0]   osrc [2];
    logic [7:0]   odst [2];
    logic         kce  [2];

    int checks   = 0;
    int failures = 0;
    int w0;
    logic [31:0] got[$];

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int P = (g == 0) ? 1 : 4;

        lii_out_packer #(
            .DW    (32),
            .PW    (128),
            .PACK  (P),
            .DEPTH (4),
            .SRC_ID(8'd0),
            .DST_ID(8'd1)
        ) dut (
            .aclk              (aclk),
            .arstn             (arstn),
            .k_tdata           (ktd[g]),
            .k_tvalid          (ktv[g]),
            .k_tready          (ktr[g]),
            .k_tlast           (ktl[g]),
            .lii_out_p0_tdata  (otd[g]),
            .lii_out_p0_tvalid (otv[g]),
            .lii_out_p0_tready (otr[g]),
            .lii_out_p0_src    (osrc[g]),
            .lii_out_p0_dst    (odst[g]),
            .ce                (kce[g])
        );

        // Model: pending words form a beat once P words or tlast arrive.
        logic [127:0] q[$];
        logic [31:0]  words[$];
        bit           run = 1'b0;

        always @(posedge aclk or negedge arstn) begin
            logic [127:0] b;
            int           sz;
            if (!arstn) begin
                q.delete();
                words.delete();
                run = 1'b0;
            end else begin
                sz = q.size();
                if (sz != 0 && otr[g]) void'(q.pop_front());
                if (run && ktv[g] && sz < 4) begin
                    words.push_back(ktd[g]);
                    if (words.size() == P || ktl[g]) begin
                        b = '0;
                        foreach (words[i]) b[i*32 +: 32] = words[i];
                        q.push_back(b);
                        words.delete();
                    end
                end
                run = 1'b1;
            end
        end

        always @(negedge aclk) begin
            chk($sformatf("u%0d_tvalid", g), 128'(otv[g]), 128'(q.size() != 0));
            chk($sformatf("u%0d_tdata", g), otd[g], (q.size() != 0) ? q[0] : 128'h0);
            chk($sformatf("u%0d_k_tready", g), 128'(ktr[g]), 128'(run && q.size() < 4));
            chk($sformatf("u%0d_ce", g), 128'(kce[g]), 128'(run && q.size() < 4));
            chk($sformatf("u%0d_src", g), 128'(osrc[g]), 128'h0);
            chk($sformatf("u%0d_dst", g), 128'(odst[g]), 128'h1);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic step0();
        bit acc;
        acc = ktv[0] && ktr[0];
        if (otv[0] && otr[0]) got.push_back(otd[0][31:0]);
        tick();
        if (acc) begin
            w0++;
            ktd[0] = 32'(w0);
            if (w0 > 6) ktv[0] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ktd[i] = '0; ktv[i] = 1'b0; ktl[i] = 1'b0; otr[i] = 1'b1;
        end
        #1;
        chk("rst_tvalid", 128'(otv[0]), 128'h0);
        chk("rst_tready", 128'(ktr[1]), 128'h0);
        repeat (3) tick();
        @(negedge aclk); #2;
        arstn = 1'b1;
        tick();
        chk("post_rst_tready", 128'(ktr[0]), 128'h1);

        // PACK=1: each word becomes its own beat one cycle after accept
        ktv[0] = 1'b1; ktd[0] = 32'hA5A5_0001;
        tick();
        chk("p1_beat1", otd[0], {96'h0, 32'hA5A5_0001});
        ktd[0] = 32'hA5A5_0002;
        tick();
        chk("p1_beat2", otd[0], {96'h0, 32'hA5A5_0002});
        ktv[0] = 1'b0;
        tick();

        // PACK=4: full beat
        ktv[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ktd[1] = 32'(i * 32'h11);
            if (i < 4) begin
                tick();
                chk("p4_no_partial", 128'(otv[1]), 128'h0);
            end else begin
                tick();
            end
        end
        chk("p4_full_beat", otd[1], 128'h00000044_00000033_00000022_00000011);
        ktv[1] = 1'b0;
        tick();

        // PACK=4: tlast flush then a fresh beat without stale lanes
        ktv[1] = 1'b1; ktd[1] = 32'h11;
        tick();
        ktd[1] = 32'h22; ktl[1] = 1'b1;
        tick();
        chk("p4_tlast_beat", otd[1], 128'h00000000_00000000_00000022_00000011);
        ktl[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ktd[1] = 32'h55 + 32'(i * 32'h11);
            tick();
        end
        chk("p4_after_tlast", otd[1], 128'h00000088_00000077_00000066_00000055);
        ktv[1] = 1'b0;
        tick();

        // PACK=1 backpressure: fill, pulse ready once, then drain
        got.delete();
        otr[0] = 1'b0; w0 = 1; ktd[0] = 32'd1; ktv[0] = 1'b1;
        repeat (6) step0();
        chk("full_tready", 128'(ktr[0]), 128'h0);
        chk("full_ce", 128'(kce[0]), 128'h0);
        chk("full_accepted", 128'(w0), 128'd5);
        otr[0] = 1'b1;
        step0();
        otr[0] = 1'b0;
        chk("pulse_tready", 128'(ktr[0]), 128'h1);
        step0();
        chk("refull_tready", 128'(ktr[0]), 128'h0);
        otr[0] = 1'b1;
        repeat (10) step0();
        chk("drain_count", 128'(got.size()), 128'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk($sformatf("drain_order%0d", i), 128'(got[i]), 128'(i + 1));
            else chk($sformatf("drain_order%0d", i), 128'hX, 128'(i + 1));
        end

        // Reset mid-operation: 3 beats buffered plus 2 lanes pending on PACK=4
        otr[1] = 1'b0; ktv[1] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            ktd[1] = 32'(32'h100 + i);
            tick();
        end
        ktv[1] = 1'b0;
        chk("pre_rst_tvalid", 128'(otv[1]), 128'h1);
        #3;
        arstn = 1'b0;
        #1;
        chk("async_rst_tvalid", 128'(otv[1]), 128'h0);
        chk("async_rst_tdata", otd[1], 128'h0);
        chk("async_rst_tready", 128'(ktr[1]), 128'h0);
        @(negedge aclk); #2;
        arstn = 1'b1;
        tick();
        chk("rel_no_beat", 128'(otv[1]), 128'h0);
        otr[1] = 1'b1; ktv[1] = 1'b1; ktl[1] = 1'b1; ktd[1] = 32'h99;
        tick();
        chk("post_rst_beat", otd[1], {96'h0, 32'h99});
        ktv[1] = 1'b0; ktl[1] = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
